// File: rtl/schieber_pkg.sv
// schieber_pkg: Modus encodings and per-stage control payload shared by the shifter pipeline.
package schieber_pkg;
  localparam logic [2:0] MODUS_SLL = 3'b000;
  localparam logic [2:0] MODUS_SRL = 3'b001;
  localparam logic [2:0] MODUS_SRA = 3'b010;
  localparam logic [2:0] MODUS_ROL = 3'b011;
  localparam logic [2:0] MODUS_ROR = 3'b100;
  typedef struct packed {
    logic       gueltig;
    logic [2:0] modus;
  } stufe_t;
endpackage

// File: rtl/schiebe_stufe.sv
// schiebe_stufe: one combinational shift/rotate step by 2**K; carry port only with SCHIEBER_UEBERTRAG_EN.
module schiebe_stufe import schieber_pkg::*; #(
  parameter int BREITE = 32,
  parameter int K = 0
) (
  input  logic [BREITE-1:0] x,
  input  logic [2:0]        modus,
  input  logic              en,
  output logic [BREITE-1:0] y
`ifdef SCHIEBER_UEBERTRAG_EN
  ,
  input  logic              ci,
  output logic              co
`endif
);
  localparam int M = 1 << K;
  logic [BREITE-1:0] sra;
  assign sra = $signed(x) >>> M;
  always_comb
    y = !en ? x :
        modus == MODUS_SLL ? x << M :
        modus == MODUS_SRL ? x >> M :
        modus == MODUS_SRA ? sra :
        modus == MODUS_ROL ? {x[BREITE-M-1:0], x[BREITE-1:BREITE-M]} :
        modus == MODUS_ROR ? {x[M-1:0], x[BREITE-1:M]} : x;
`ifdef SCHIEBER_UEBERTRAG_EN
  // the last active step's outgoing/wrapped bit is the final carry, so later idle steps just pass it on
  always_comb
    co = !en ? ci :
         (modus == MODUS_SLL || modus == MODUS_ROL) ? x[BREITE-M] :
         (modus == MODUS_SRL || modus == MODUS_SRA || modus == MODUS_ROR) ? x[M-1] : ci;
`endif
endmodule

// File: rtl/pipeline_schieber.sv
// pipeline_schieber: STUFEN-stage barrel shifter with valid/ready flow control.
// Optional Uebertrag output enabled by SCHIEBER_UEBERTRAG_EN.
module pipeline_schieber import schieber_pkg::*; #(
  parameter int BREITE = 32,
  parameter int STUFEN = 2,
  localparam int LOG2BREITE = $clog2(BREITE)
) (
  input  logic                  Takt,
  input  logic                  Reset,
  input  logic                  EingabeGueltig,
  output logic                  EingabeBereit,
  input  logic [BREITE-1:0]     Zahl,
  input  logic [LOG2BREITE-1:0] Stellen,
  input  logic [2:0]            Modus,
  output logic                  AusgabeGueltig,
  input  logic                  AusgabeBereit,
  output logic [BREITE-1:0]     Ergebnis
`ifdef SCHIEBER_UEBERTRAG_EN
  ,
  output logic                  Uebertrag
`endif
);
  localparam int PRO = (LOG2BREITE + STUFEN - 1) / STUFEN;
  stufe_t kopf [STUFEN];
  stufe_t nk [STUFEN];
  logic [BREITE-1:0] daten [STUFEN];
  logic [BREITE-1:0] nd [STUFEN];
  logic [LOG2BREITE-1:0] rest [STUFEN];
  logic [LOG2BREITE-1:0] nr [STUFEN];
  logic [STUFEN:0] weiter;
`ifdef SCHIEBER_UEBERTRAG_EN
  logic ueb [STUFEN];
  logic nc [STUFEN];
`endif
  assign weiter[STUFEN] = AusgabeBereit;
  assign EingabeBereit = !Reset && weiter[0];
  assign AusgabeGueltig = kopf[STUFEN-1].gueltig;
  assign Ergebnis = daten[STUFEN-1];
  for (genvar s = 0; s < STUFEN; s++) begin : g_stufe
    logic [BREITE-1:0] kette [PRO+1];
    logic [2:0] modus;
    logic [LOG2BREITE-1:0] stellen;
`ifdef SCHIEBER_UEBERTRAG_EN
    logic kc [PRO+1];
`endif
    if (s == 0) begin : g_ein
      assign kette[0] = Zahl;
      assign modus = Modus;
      assign stellen = Stellen;
      assign nk[s] = {EingabeGueltig && EingabeBereit, Modus};
`ifdef SCHIEBER_UEBERTRAG_EN
      assign kc[0] = 1'b0;
`endif
    end else begin : g_mitte
      assign kette[0] = daten[s-1];
      assign modus = kopf[s-1].modus;
      assign stellen = rest[s-1];
      assign nk[s] = kopf[s-1];
`ifdef SCHIEBER_UEBERTRAG_EN
      assign kc[0] = ueb[s-1];
`endif
    end
    // stage s owns steps s*PRO .. s*PRO+PRO-1; steps past LOG2BREITE are pass-through
    for (genvar j = 0; j < PRO; j++) begin : g_schritt
      if (s * PRO + j < LOG2BREITE) begin : g_an
        schiebe_stufe #(.BREITE(BREITE), .K(s * PRO + j)) u_stufe (
          .x(kette[j]),
          .modus(modus),
          .en(stellen[s*PRO+j]),
          .y(kette[j+1])
`ifdef SCHIEBER_UEBERTRAG_EN
          ,
          .ci(kc[j]),
          .co(kc[j+1])
`endif
        );
      end else begin : g_aus
        assign kette[j+1] = kette[j];
`ifdef SCHIEBER_UEBERTRAG_EN
        assign kc[j+1] = kc[j];
`endif
      end
    end
    assign nd[s] = kette[PRO];
    assign nr[s] = stellen;
    assign weiter[s] = !kopf[s].gueltig || weiter[s+1];
`ifdef SCHIEBER_UEBERTRAG_EN
    assign nc[s] = kc[PRO];
`endif
  end
  always_ff @(posedge Takt)
    for (int s = 0; s < STUFEN; s++)
      if (Reset) begin
        kopf[s] <= '0;
        daten[s] <= '0;
        rest[s] <= '0;
      end else if (weiter[s]) begin
        kopf[s] <= nk[s];
        if (nk[s].gueltig) begin
          daten[s] <= nd[s];
          rest[s] <= nr[s];
        end
      end
`ifdef SCHIEBER_UEBERTRAG_EN
  assign Uebertrag = ueb[STUFEN-1];
  always_ff @(posedge Takt)
    for (int s = 0; s < STUFEN; s++)
      if (Reset) ueb[s] <= 1'b0;
      else if (weiter[s] && nk[s].gueltig) ueb[s] <= nc[s];
`endif
endmodule

// File: doc/pipeline_schieber.md
PIPELINE_SCHIEBER -- requirements
Module: pipeline_schieber

Interface
REQ-001 SHALL have parameter BREITE, default 32: data width in bits, power of two, 8..64.
REQ-002 SHALL have parameter STUFEN, default 2: register stages, 1..$clog2(BREITE).
REQ-003 SHALL have derived localparam LOG2BREITE = $clog2(BREITE); it is not a port-level override.
REQ-004 SHALL have: Takt  in  1  sole clock, rising edge.
REQ-005 SHALL have: Reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have: EingabeGueltig  in  1  input operand valid.
REQ-007 SHALL have: EingabeBereit  out  1  block accepts input this cycle.
REQ-008 SHALL have: Zahl  in  BREITE  operand.
REQ-009 SHALL have: Stellen  in  LOG2BREITE  shift amount, 0..BREITE-1.
REQ-010 SHALL have: Modus  in  3  operation code (REQ-014).
REQ-011 SHALL have: AusgabeGueltig  out  1  result valid.
REQ-012 SHALL have: AusgabeBereit  in  1  downstream accepts result.
REQ-013 SHALL have: Ergebnis  out  BREITE  result.

Function
REQ-014 Modus SHALL encode: 000 SLL, 001 SRL, 010 SRA (sign fill), 011 ROL, 100 ROR; 101..111 pass Zahl unchanged.
REQ-015 Rotations SHALL be exact modulo BREITE; Stellen=0 SHALL return Zahl in every mode.
REQ-016 Transfer SHALL occur on a rising edge where EingabeGueltig && EingabeBereit (input) or AusgabeGueltig && AusgabeBereit (output).
REQ-017 LOG2BREITE binary shift steps (1,2,4,...) SHALL be split across STUFEN registers, ceil(LOG2BREITE/STUFEN) steps per stage, the last stage taking the remainder.
REQ-018 Latency SHALL be exactly STUFEN cycles from accepted input to AusgabeGueltig when never stalled.
REQ-019 Throughput SHALL be one operation per cycle while AusgabeBereit=1.
REQ-020 Each stage SHALL carry valid bit, partial result, remaining Stellen bits, and Modus.
REQ-021 A stage SHALL advance when empty or when its successor advances (bubble-collapsing); EingabeBereit = stage 0 empty or stage 0 advancing.
REQ-022 While AusgabeGueltig=1 and AusgabeBereit=0, Ergebnis and AusgabeGueltig SHALL hold stable.
REQ-023 When full and stalled, EingabeBereit SHALL be 0 and no operand SHALL be lost or duplicated.
REQ-024 EingabeBereit SHALL be combinational from AusgabeBereit and stage valids only, never from EingabeGueltig.
REQ-025 Results SHALL emerge in input order.

Reset
REQ-026 Reset=1 at a rising edge SHALL clear all stage valid bits; AusgabeGueltig=0, Ergebnis=0 next cycle.
REQ-027 Reset mid-operation SHALL discard in-flight operations; no result of them SHALL appear.
REQ-028 During Reset, EingabeBereit SHALL be 0; input presented in that cycle SHALL be dropped.

Configuration
REQ-029 Macro SCHIEBER_UEBERTRAG_EN SHALL, when defined, add output Uebertrag (1 bit): last bit shifted out for SLL/SRL/SRA, 0 when Stellen=0, bit wrapped into Ergebnis[0] (ROL) / Ergebnis[BREITE-1] (ROR), 0 for pass modes; pipelined and stalled identically to Ergebnis, reset to 0.
REQ-030 Without SCHIEBER_UEBERTRAG_EN the port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Package schieber_pkg SHALL hold the Modus encodings and the stage payload struct typedef.
REQ-032 Sub-module schiebe_stufe SHALL implement one combinational shift step (amount 2^k, mode-aware fill), instantiated LOG2BREITE times.

Verification (BREITE=32, STUFEN=2 unless stated)
REQ-033 Zahl=0x8000_0001, Stellen=1, ROL, AusgabeBereit=1 -> Ergebnis=0x0000_0003 exactly 2 cycles later; Uebertrag=1 if enabled.
REQ-034 Zahl=0x8000_0000, Stellen=31, SRA -> 0xFFFF_FFFF; same with SRL -> 0x0000_0001.
REQ-035 Stream 8 back-to-back ops, AusgabeBereit=0 for cycles 3..6 -> EingabeBereit falls once both stages full, outputs held stable, all 8 results in order, none lost.
REQ-036 Reset asserted with 2 ops in flight -> no AusgabeGueltig for those ops; next op after reset returns correct result with latency 2.
REQ-037 Random exhaustive mode/Stellen sweep for STUFEN=1 and STUFEN=5 against reference model -> zero mismatches; Modus=111 -> Ergebnis=Zahl.
